dff_bank_arbiter: RTL
=====================

// Module: dff_bank_arbiter
// PURPOSE
//  Round-robin write arbiter for a shared bank of DFF registers: NUM_REQ requesters compete
//  for one write port, one write commits per cycle. Registered read port for consumers.
//  Sits between requester logic and the DFF storage, sequencing every write into the bank.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  DATA_W   8  register width in bits
//  DEPTH    4  registers in the bank (power of 2); localparam AW = $clog2(DEPTH)
// PORTS
//  clk      in   1               rising-edge clock, single domain
//  reset    in   1               synchronous, active-low reset (sampled on clk rising edge)
//  req      in   NUM_REQ         per-requester write request, level, held until gnt
//  waddr    in   NUM_REQ*AW      packed write addresses, requester i at [i*AW +: AW]
//  wdata    in   NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
//  gnt      out  NUM_REQ         one-hot registered grant; the write has committed
//  conflict out  1               registered pulse: >1 eligible request in arbitrated cycle
//  rd_addr  in   AW              read address
//  rd_data  out  DATA_W          registered read data
// BEHAVIOUR
//  - Reset (reset==0 at edge): gnt=0, conflict=0, rd_data=0, ptr=0, all bank regs=0.
//    Reset overrides everything in that cycle; in-flight requests are dropped, not queued.
//  - Eligible: elig[i] = req[i] & ~gnt[i] (a requester whose gnt is high is masked this cycle).
//  - Each edge: winner = first set elig bit scanning ptr, ptr+1, ... mod NUM_REQ.
//    Same edge: bank[waddr[winner]] <= wdata[winner]; gnt <= onehot(winner);
//    ptr <= (winner+1) mod NUM_REQ. No eligible req: gnt<=0, ptr and bank unchanged.
//  - Latency: req sampled at edge k -> gnt high during cycle k+1, data readable from k+1.
//  - Handshake: requester drops req (or presents new addr/data) in the cycle its gnt is high;
//    masking forces >=1 idle cycle between grants to the same requester.
//  - Throughput: 1 write/cycle with >=2 active requesters.
//  - conflict <= (popcount(elig) > 1); purely informational.
//  - Read: rd_data <= bank[rd_addr] each edge (1-cycle latency). Read and write to the same
//    address on one edge returns the OLD value; new value visible the following cycle.
//  - waddr/wdata of non-winners are ignored; out-of-range never occurs (DEPTH power of 2).
// CONFIGURATION
//  - Macro ARB_FIXED_PRIO_EN. Defined: fixed priority, lowest index wins, ptr held at 0;
//    masking rule unchanged. Undefined (default): round-robin as above.
// STRUCTURE
//  - Package dff_bank_pkg: default NUM_REQ/DATA_W/DEPTH constants, rr_pick function
//    (elig, ptr -> winner index + valid), onehot helper.
//  - One sub-module: dff_reg_bank (DEPTH x DATA_W DFF storage, 1 write port with
//    wen/waddr/wdata, 1 registered read port, sync active-low reset to 0).
//  - Top holds arbiter: ptr, gnt, conflict registers and winner mux.
// TESTING
//  1 reset=0 for 3 cycles with req=4'b1111 -> gnt=0, rd_data=0, all bank regs read back 0.
//  2 Only req[2], waddr=1, wdata=8'hA5 -> gnt=4'b0100 next cycle; rd_addr=1 gives 8'hA5
//    one cycle after that; ptr=3.
//  3 req=4'b1111 held, each requester drops req during its own gnt -> gnt sequence
//    0001,0010,0100,1000; conflict=1 first 3 grants, 0 on last.
//  4 req[0] and req[1] never dropped -> grants alternate 0001,0010,0001,...; req[0] never
//    granted two cycles in a row.
//  5 Write 8'h3C to addr 2 while rd_addr=2 holding 8'h11 -> rd_data=8'h11 that cycle,
//    8'h3C the next.
//  6 reset=0 asserted the cycle after req[3] granted -> gnt=0, bank all 0; with
//    ARB_FIXED_PRIO_EN and req=4'b1010 -> req[1] wins first, req[3] next (masking).

Source files
------------

// File: rtl/dff_bank_arbiter_pkg.sv
// dff_bank_pkg: default sizes plus the round-robin pick and one-hot helpers shared by dff_bank_arbiter.
// Helpers take a MAX_REQ-wide vector so any NUM_REQ up to 32 can use them.
package dff_bank_pkg;
   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF = 4;
   localparam int MAX_REQ = 32;
   localparam int IDX_W = $clog2(MAX_REQ);
   typedef struct packed {
      logic valid;
      logic [IDX_W-1:0] idx;
   } pick_t;
   // Scan downwards so the last hit, which is the one closest to ptr, wins.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] elig, input int ptr, input int n);
      pick_t p;
      p = '0;
      for (int k = n - 1; k >= 0; k--)
         if (elig[(ptr + k) % n]) p = '{valid: 1'b1, idx: IDX_W'((ptr + k) % n)};
      return p;
   endfunction
   function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return MAX_REQ'(1) << idx;
   endfunction
endpackage

// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: requester-side write requests/grants and the consumer read port.
interface dff_bank_arbiter_if
   import dff_bank_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF
);
   localparam int AW = $clog2(DEPTH);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ*AW-1:0] waddr;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0] gnt;
   logic conflict;
   logic [AW-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   modport master (output req, waddr, wdata, rd_addr, input gnt, conflict, rd_data);
   modport slave (input req, waddr, wdata, rd_addr, output gnt, conflict, rd_data);
endinterface

// File: rtl/dff_bank_arbiter_reg_bank.sv
// dff_reg_bank: DEPTH x DATA_W flop storage, one write port, one registered read port.
// A same-edge read and write to one address returns the old contents.
module dff_reg_bank #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wen,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
         if (wen) mem[waddr] <= wdata;
      end
   end
endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin write arbiter in front of a DFF register bank, one write per cycle.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr stays 0).
module dff_bank_arbiter
   import dff_bank_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input logic clk,
   input logic reset,
   dff_bank_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(NUM_REQ);
   logic [PW-1:0] ptr;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] elig;
   logic conflict;
   pick_t pk;
   // A requester holding gnt is masked, forcing an idle cycle before its next grant.
   assign elig = bus.req & ~gnt;
   assign pk = rr_pick(MAX_REQ'(elig), int'(ptr), NUM_REQ);
   assign bus.gnt = gnt;
   assign bus.conflict = conflict;
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= '0;
         gnt <= '0;
         conflict <= 1'b0;
      end else begin
         gnt <= pk.valid ? NUM_REQ'(onehot(pk.idx)) : '0;
         conflict <= $countones(elig) > 1;
`ifdef ARB_FIXED_PRIO_EN
         ptr <= '0;
`else
         if (pk.valid) ptr <= PW'((int'(pk.idx) + 1) % NUM_REQ);
`endif
      end
   end
   dff_reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
      .clk(clk),
      .reset(reset),
      .wen(pk.valid),
      .waddr(bus.waddr[int'(pk.idx)*AW +: AW]),
      .wdata(bus.wdata[int'(pk.idx)*DATA_W +: DATA_W]),
      .rd_addr(bus.rd_addr),
      .rd_data(bus.rd_data)
   );
endmodule
